// File: rtl/tri_bus_arbiter.sv
// Round-robin arbiter handing a shared tri-state bus to one of N drivers,
// with a setup cycle before enable, a hold limit, and idle turnaround between owners.
module tri_bus_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  parameter int TURN_CYC = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  output logic [N-1:0]         bus_en,
  output logic [$clog2(N)-1:0] owner,
  output logic                 busy,
  output logic                 timeout
);

  localparam int W  = $clog2(N);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam int TW = $clog2(TURN_CYC + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SETUP = 2'd1;
  localparam logic [1:0] DRIVE = 2'd2;
  localparam logic [1:0] TURN  = 2'd3;

  logic [1:0]    state_r, state_s;
  logic [W-1:0]  cur_r, cur_s;
  logic [W-1:0]  rr_r, rr_s;
  logic [HW-1:0] hold_r, hold_s;
  logic [TW-1:0] turn_r, turn_s;
  logic [N-1:0]  gnt_s, en_s;
  logic [W-1:0]  owner_s;
  logic          busy_s, timeout_s;
  logic [W:0]    pick_s;

  // {found, index} of the first requester at or after p, wrapping N-1 to 0
  function automatic logic [W:0] rr_pick(input logic [N-1:0] r, input logic [W-1:0] p);
    logic [W:0] res;
    logic [W:0] s;
    res = '0;
    for (int i = N - 1; i >= 0; i--) begin
      s   = {1'b0, p} + (W+1)'(i);
      s   = (s >= (W+1)'(N)) ? (s - (W+1)'(N)) : s;
      res = r[s[W-1:0]] ? {1'b1, s[W-1:0]} : res;
    end
    return res;
  endfunction

  function automatic logic [W-1:0] wrap_inc(input logic [W-1:0] p);
    logic [W:0] s;
    s = {1'b0, p} + {{W{1'b0}}, 1'b1};
    s = (s >= (W+1)'(N)) ? (s - (W+1)'(N)) : s;
    return s[W-1:0];
  endfunction

  // Next-state and next-output decode; outputs are the registered copies of these
  always_comb begin
    state_s   = state_r;
    cur_s     = cur_r;
    rr_s      = rr_r;
    hold_s    = hold_r;
    turn_s    = turn_r;
    gnt_s     = gnt;
    en_s      = bus_en;
    owner_s   = owner;
    busy_s    = busy;
    timeout_s = 1'b0;
    pick_s    = rr_pick(req, rr_r);
    case (state_r)
      IDLE: begin
        if (pick_s[W]) begin
          state_s = SETUP;
          cur_s   = pick_s[W-1:0];
          rr_s    = wrap_inc(pick_s[W-1:0]);
          gnt_s   = N'(1) << pick_s[W-1:0];
          en_s    = '0;
          owner_s = pick_s[W-1:0];
          busy_s  = 1'b1;
        end else begin
          gnt_s   = '0;
          en_s    = '0;
          owner_s = '0;
          busy_s  = 1'b0;
        end
      end
      SETUP: begin
        if (req[cur_r]) begin
          state_s = DRIVE;
          en_s    = N'(1) << cur_r;
          hold_s  = HW'(1);
        end else begin
          // Requester gave up before the bus was ever driven
          state_s = IDLE;
          gnt_s   = '0;
          en_s    = '0;
          owner_s = '0;
          busy_s  = 1'b0;
        end
      end
      DRIVE: begin
        if (!req[cur_r] || (hold_r == HW'(MAX_HOLD))) begin
          state_s   = TURN;
          gnt_s     = '0;
          en_s      = '0;
          owner_s   = '0;
          busy_s    = 1'b0;
          hold_s    = '0;
          turn_s    = TW'(1);
          timeout_s = req[cur_r];
        end else begin
          hold_s = hold_r + HW'(1);
        end
      end
      TURN: begin
        if (turn_r == TW'(TURN_CYC)) begin
          state_s = IDLE;
          turn_s  = '0;
        end else begin
          turn_s  = turn_r + TW'(1);
        end
      end
      default: begin
        state_s = IDLE;
        cur_s   = '0;
        rr_s    = '0;
        hold_s  = '0;
        turn_s  = '0;
        gnt_s   = '0;
        en_s    = '0;
        owner_s = '0;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset floats the bus without waiting for a clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cur_r   <= '0;
      rr_r    <= '0;
      hold_r  <= '0;
      turn_r  <= '0;
      gnt     <= '0;
      bus_en  <= '0;
      owner   <= '0;
      busy    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state_r <= state_s;
      cur_r   <= cur_s;
      rr_r    <= rr_s;
      hold_r  <= hold_s;
      turn_r  <= turn_s;
      gnt     <= gnt_s;
      bus_en  <= en_s;
      owner   <= owner_s;
      busy    <= busy_s;
      timeout <= timeout_s;
    end
  end

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Directed bench for tri_bus_arbiter: vector table plus multi-cycle sequences
// for hold timeout, regrant, async reset and full contention.
module tb_tri_bus_arbiter;

  localparam int N  = 4;
  localparam int MH = 8;
  localparam int TC = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt;
  logic [3:0] bus_en;
  logic [1:0] owner;
  logic       busy;
  logic       timeout;

  int   nvec = 0;
  int   nerr = 0;
  int   low_run = 0;
  logic seen = 1'b0;
  logic [3:0] prev_en = 4'b0000;

  typedef struct {
    logic [3:0] rq;
    logic [3:0] g;
    logic [3:0] e;
    logic [1:0] o;
    logic       b;
    logic       t;
  } vec_t;

  vec_t tbl [17];

  tri_bus_arbiter #(.N(N), .MAX_HOLD(MH), .TURN_CYC(TC)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .bus_en(bus_en),
    .owner(owner), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [3:0] g, input logic [3:0] e,
                     input logic [1:0] o, input logic b, input logic t);
    nvec++;
    if (gnt !== g || bus_en !== e || owner !== o || busy !== b || timeout !== t) begin
      nerr++;
      $display("FAIL %s: got gnt=%b en=%b owner=%0d busy=%b timeout=%b, want gnt=%b en=%b owner=%0d busy=%b timeout=%b",
               nm, gnt, bus_en, owner, busy, timeout, g, e, o, b, t);
    end
  endtask

  // Advance one clock, then check one-hot enable and the owner-to-owner gap
  task automatic step();
    @(posedge clk);
    #1;
    nvec++;
    if (!$onehot0(bus_en)) begin
      nerr++;
      $display("FAIL onehot0: bus_en=%b, want at most one bit high", bus_en);
    end
    if (prev_en == 4'b0000 && bus_en != 4'b0000) begin
      if (seen) begin
        nvec++;
        if (low_run < TC + 2) begin
          nerr++;
          $display("FAIL gap: idle cycles=%0d, want >= %0d", low_run, TC + 2);
        end
      end
      seen = 1'b1;
    end
    low_run = (bus_en == 4'b0000) ? low_run + 1 : 0;
    prev_en = bus_en;
  endtask

  initial begin
    tbl[0]  = '{4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
    tbl[1]  = '{4'b0001, 4'b0001, 4'b0000, 2'd0, 1'b1, 1'b0};
    tbl[2]  = '{4'b0001, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0};
    tbl[3]  = '{4'b0001, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0};
    tbl[4]  = '{4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
    tbl[5]  = '{4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
    tbl[6]  = '{4'b0100, 4'b0100, 4'b0000, 2'd2, 1'b1, 1'b0};
    tbl[7]  = '{4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
    tbl[8]  = '{4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
    tbl[9]  = '{4'b1001, 4'b1000, 4'b0000, 2'd3, 1'b1, 1'b0};
    tbl[10] = '{4'b1001, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0};
    tbl[11] = '{4'b0001, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
    tbl[12] = '{4'b0001, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
    tbl[13] = '{4'b0001, 4'b0001, 4'b0000, 2'd0, 1'b1, 1'b0};
    tbl[14] = '{4'b0001, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0};
    tbl[15] = '{4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
    tbl[16] = '{4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};

    #12;
    chk("reset", 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single request, SETUP abort, round-robin wrap from rr_ptr=3
    for (int i = 0; i < 17; i++) begin
      req = tbl[i].rq;
      step();
      chk($sformatf("vec%0d", i), tbl[i].g, tbl[i].e, tbl[i].o, tbl[i].b, tbl[i].t);
    end

    // Lone driver 2 forced off at MAX_HOLD, then regranted
    req = 4'b0100;
    step(); chk("lone_setup", 4'b0100, 4'b0000, 2'd2, 1'b1, 1'b0);
    for (int c = 1; c <= MH; c++) begin
      step(); chk($sformatf("lone_drive%0d", c), 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0);
    end
    step(); chk("lone_turn_timeout", 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b1);
    step(); chk("lone_idle", 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    step(); chk("lone_regrant", 4'b0100, 4'b0000, 2'd2, 1'b1, 1'b0);
    for (int c = 1; c <= MH; c++) begin
      step(); chk($sformatf("regrant_drive%0d", c), 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0);
    end
    // Request drops exactly at MAX_HOLD: no timeout pulse
    req = 4'b0000;
    step(); chk("drop_at_max", 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    step(); chk("drop_idle", 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

    // Reset mid-DRIVE, then arbitration restarts from rr_ptr=0
    req = 4'b0010;
    step(); chk("pre_rst_setup", 4'b0010, 4'b0000, 2'd1, 1'b1, 1'b0);
    step(); chk("pre_rst_drive", 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset", 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    req = 4'b1010;
    step(); chk("post_rst_grant", 4'b0010, 4'b0000, 2'd1, 1'b1, 1'b0);
    step(); chk("post_rst_drive", 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0);
    req = 4'b0000;
    step(); chk("post_rst_turn", 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    step(); chk("post_rst_idle", 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

    // Full contention from a fresh reset: order 0,1,2,3,0, each forced off
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      logic [1:0] k;
      logic [3:0] oh;
      k  = 2'(n % 4);
      oh = 4'b0001 << k;
      step(); chk($sformatf("cont%0d_setup", n), oh, 4'b0000, k, 1'b1, 1'b0);
      for (int c = 1; c <= MH; c++) begin
        step(); chk($sformatf("cont%0d_drive%0d", n, c), oh, oh, k, 1'b1, 1'b0);
      end
      step(); chk($sformatf("cont%0d_turn", n), 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b1);
      step(); chk($sformatf("cont%0d_idle", n), 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    end
    req = 4'b0000;
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
